parking_entry_frontend: RTL

//  Front-end stage directly upstream of parking_system. Debounces raw entrance/exit sensors and collects
//  a two-digit keypad code. Presents stable sensor_entrance, sensor_exit, password_1 and password_2
//  to the parking controller. Outputs stay constant while the controller evaluates them.

---
 rtl/parking_entry_frontend.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/parking_entry_frontend.sv
// parking_entry_frontend
// Debounces the entrance/exit sensors and collects a two-digit keypad code
// for the downstream parking controller. The password outputs only change on
// a submit, an abort (entrance fall or timeout) or reset, so the controller
// always evaluates stable values.
//
// Keypad strobes: key_valid, key_enter and key_clear are single-cycle,
// fire-and-forget strobes with no ready/back-pressure. A strobe is consumed
// on the rising edge where it is high if the current state accepts it, and
// it is silently dropped otherwise. key_code is only looked at together with
// an accepted key_valid.
module parking_entry_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_valid,
    output logic       entry_busy,
    output logic       timeout_flag,
    output logic [2:0] fsm_state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_D1    = 3'd1,
        S_WAIT_D2    = 3'd2,
        S_WAIT_ENTER = 3'd3,
        S_HOLD       = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Sensor debounce: index 0 = entrance, index 1 = exit
    // ------------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    deb_q, deb_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    logic          ent_prev_q;
    logic          ent_rise, ent_fall;

    assign raw = {raw_exit, raw_entrance};

    // Count consecutive disagreeing cycles; flip the output on the last one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (raw[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Debounce state and the delayed entrance copy used for edge strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_q      <= '0;
            dcnt_q[0]  <= '0;
            dcnt_q[1]  <= '0;
            ent_prev_q <= 1'b0;
        end else begin
            deb_q      <= deb_d;
            dcnt_q[0]  <= dcnt_d[0];
            dcnt_q[1]  <= dcnt_d[1];
            ent_prev_q <= deb_q[0];
        end
    end

    assign sensor_entrance = deb_q[0];
    assign sensor_exit     = deb_q[1];
    assign ent_rise        = deb_q[0] & ~ent_prev_q;
    assign ent_fall        = ~deb_q[0] & ent_prev_q;

    // ------------------------------------------------------------------
    // Entry FSM with digit latches, password outputs and idle timeout
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [1:0]    d1_q, d1_d, d2_q, d2_d;
    logic [1:0]    pw1_q, pw1_d, pw2_q, pw2_d;
    logic          pw_valid_q, pw_valid_d;
    logic          tflag_q, tflag_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          in_wait;
    logic [TW-1:0] tcnt_inc;

    assign in_wait  = (state_q == S_WAIT_D1) || (state_q == S_WAIT_D2) ||
                      (state_q == S_WAIT_ENTER);
    assign tcnt_inc = (tcnt_q == TMO_LAST) ? tcnt_q : tcnt_q + TW'(1);

    // Next state: ent_fall beats timeout beats key_clear beats enter/valid.
    // tcnt_d defaults to 0, so only the "nothing accepted" paths keep counting.
    always_comb begin
        state_d    = state_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        pw1_d      = pw1_q;
        pw2_d      = pw2_q;
        pw_valid_d = 1'b0;
        tflag_d    = 1'b0;
        tcnt_d     = '0;

        if (state_q != S_IDLE && ent_fall) begin
            state_d = S_IDLE;
            d1_d    = '0;
            d2_d    = '0;
            pw1_d   = '0;
            pw2_d   = '0;
        end else if (in_wait && tcnt_q == TMO_LAST) begin
            state_d = S_IDLE;
            d1_d    = '0;
            d2_d    = '0;
            pw1_d   = '0;
            pw2_d   = '0;
            tflag_d = 1'b1;
        end else if (state_q != S_IDLE && key_clear) begin
            // Restart digit entry; the last submitted password stays visible.
            state_d = S_WAIT_D1;
            d1_d    = '0;
            d2_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ent_rise) state_d = S_WAIT_D1;
                end
                S_WAIT_D1: begin
                    if (key_valid) begin
                        d1_d    = key_code;
                        state_d = S_WAIT_D2;
                    end else begin
                        tcnt_d = tcnt_inc;
                    end
                end
                S_WAIT_D2: begin
                    if (key_valid) begin
                        d2_d    = key_code;
                        state_d = S_WAIT_ENTER;
                    end else begin
                        tcnt_d = tcnt_inc;
                    end
                end
                S_WAIT_ENTER: begin
                    if (key_enter) begin
                        pw1_d      = d1_q;
                        pw2_d      = d2_q;
                        pw_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        tcnt_d = tcnt_inc;
                    end
                end
                S_HOLD: begin
                    state_d = S_HOLD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            d1_q       <= '0;
            d2_q       <= '0;
            pw1_q      <= '0;
            pw2_q      <= '0;
            pw_valid_q <= 1'b0;
            tflag_q    <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            pw1_q      <= pw1_d;
            pw2_q      <= pw2_d;
            pw_valid_q <= pw_valid_d;
            tflag_q    <= tflag_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign password_1   = pw1_q;
    assign password_2   = pw2_q;
    assign pw_valid     = pw_valid_q;
    assign timeout_flag = tflag_q;
    assign entry_busy   = in_wait;
    assign fsm_state    = state_q;

endmodule
